redmule_mx_w_packer: RTL and testbench

REDMULE_MX_W_PACKER -- requirements
Module: redmule_mx_w_packer

---
 rtl/redmule_mx_w_packer.sv | 136 +++++++++++++
 tb/tb_redmule_mx_w_packer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_mx_w_packer.sv
// Splits the MX weight stream (exponent beat + up to BLKS_PER_EXP value beats) into value/exponent pairs.
// Define REDMULE_MX_WPACK_REG_EN to register the output pair (latency 1, full throughput).
module redmule_mx_w_packer #(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned NUM_LANES = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [15:0]            num_val_beats_i,
    output logic                   busy_o,
    output logic                   done_o,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_W-1:0]      in_data_i,
    output logic                   mx_val_valid_o,
    input  logic                   mx_val_ready_i,
    output logic [DATA_W-1:0]      mx_val_data_o,
    output logic                   mx_exp_valid_o,
    input  logic                   mx_exp_ready_i,
    output logic [NUM_LANES*8-1:0] mx_exp_data_o
);
    localparam int unsigned NUM_GROUPS   = DATA_W / 8 / NUM_LANES;
    localparam int unsigned EXP_PER_BEAT = DATA_W / 8;
    localparam int unsigned BLKS_PER_EXP = EXP_PER_BEAT / NUM_GROUPS;
    localparam int unsigned GRP_W        = NUM_GROUPS * 8;
    localparam int unsigned EXP_W        = NUM_LANES * 8;
    localparam int unsigned BLK_W        = (BLKS_PER_EXP > 1) ? $clog2(BLKS_PER_EXP) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXP  = 2'd1;
    localparam logic [1:0] S_VAL  = 2'd2;

    logic [1:0]        state_q;
    logic [15:0]       remaining_q;
    logic [BLK_W-1:0]  blk_cnt_q;
    logic [DATA_W-1:0] exp_reg_q;
    logic              done_zero_q;
    logic [EXP_W-1:0]  exp_slice;
    logic              pair_xfer, in_fire, val_accept, last_beat, start_ok;

    always_comb begin
        exp_slice = '0;
        exp_slice[GRP_W-1:0] = exp_reg_q[blk_cnt_q*GRP_W +: GRP_W];
    end

    assign pair_xfer  = mx_val_valid_o && mx_val_ready_i && mx_exp_ready_i;
    assign in_fire    = in_valid_i && in_ready_o;
    assign val_accept = (state_q == S_VAL) && in_fire;
    assign last_beat  = (remaining_q == 16'd1);
    assign start_ok   = start_i && !busy_o;

`ifdef REDMULE_MX_WPACK_REG_EN
    logic              out_full_q, out_last_q;
    logic [DATA_W-1:0] out_val_q;
    logic [EXP_W-1:0]  out_exp_q;

    // The slot refills in the same cycle it drains, so back-to-back pairs keep full rate.
    assign in_ready_o     = (state_q == S_EXP) ||
                            ((state_q == S_VAL) && (!out_full_q || pair_xfer));
    assign mx_val_valid_o = out_full_q;
    assign mx_exp_valid_o = out_full_q;
    assign mx_val_data_o  = out_val_q;
    assign mx_exp_data_o  = out_exp_q;
    assign busy_o         = (state_q != S_IDLE) || out_full_q;
    assign done_o         = done_zero_q || (pair_xfer && out_last_q && !rst_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_full_q <= 1'b0;
            out_last_q <= 1'b0;
            out_val_q  <= '0;
            out_exp_q  <= '0;
        end else if (val_accept) begin
            out_full_q <= 1'b1;
            out_last_q <= last_beat;
            out_val_q  <= in_data_i;
            out_exp_q  <= exp_slice;
        end else if (pair_xfer) begin
            out_full_q <= 1'b0;
        end
    end
`else
    assign in_ready_o     = (state_q == S_EXP) ||
                            ((state_q == S_VAL) && mx_val_ready_i && mx_exp_ready_i);
    assign mx_val_valid_o = (state_q == S_VAL) && in_valid_i;
    assign mx_exp_valid_o = mx_val_valid_o;
    assign mx_val_data_o  = (state_q == S_VAL) ? in_data_i : '0;
    assign mx_exp_data_o  = (state_q == S_VAL) ? exp_slice : '0;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = done_zero_q || (val_accept && last_beat && !rst_i);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            blk_cnt_q   <= '0;
            exp_reg_q   <= '0;
            done_zero_q <= 1'b0;
        end else begin
            done_zero_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        if (num_val_beats_i == 16'd0) begin
                            done_zero_q <= 1'b1;
                        end else begin
                            remaining_q <= num_val_beats_i;
                            blk_cnt_q   <= '0;
                            state_q     <= S_EXP;
                        end
                    end
                end
                S_EXP: begin
                    if (in_fire) begin
                        exp_reg_q <= in_data_i;
                        state_q   <= S_VAL;
                    end
                end
                S_VAL: begin
                    if (val_accept) begin
                        remaining_q <= remaining_q - 16'd1;
                        blk_cnt_q   <= (blk_cnt_q == BLK_W'(BLKS_PER_EXP - 1)) ? '0 : blk_cnt_q + 1'b1;
                        // A short final group ends the job here instead of waiting for a full block.
                        if (last_beat)
                            state_q <= S_IDLE;
                        else if (blk_cnt_q == BLK_W'(BLKS_PER_EXP - 1))
                            state_q <= S_EXP;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_redmule_mx_w_packer.sv
// Randomized bench for redmule_mx_w_packer; expected pairs come from a byte-level model of the stream format.
module tb_redmule_mx_w_packer;
    localparam int DATA_W = 256;
    localparam int NUM_LANES = 8;
    localparam int EXP_W = NUM_LANES * 8;
    localparam int BLKS = 8;
    localparam int GRPS = 4;

    logic              clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0]       num = '0;
    logic              busy, done, in_valid = 1'b0, in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              val_valid, val_ready = 1'b1, exp_valid, exp_ready = 1'b1;
    logic [DATA_W-1:0] val_data;
    logic [EXP_W-1:0]  exp_data;

    redmule_mx_w_packer #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .num_val_beats_i(num),
        .busy_o(busy), .done_o(done),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .mx_val_valid_o(val_valid), .mx_val_ready_i(val_ready), .mx_val_data_o(val_data),
        .mx_exp_valid_o(exp_valid), .mx_exp_ready_i(exp_ready), .mx_exp_data_o(exp_data)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;
    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] exp_val_q[$];
    logic [EXP_W-1:0]  exp_exp_q[$];
    int rdy_mode = 0;
    bit gaps = 0;
    int pairs = 0, dones = 0;
    bit prev_stall = 0;
    logic [DATA_W-1:0] held_val;
    logic [EXP_W-1:0]  held_exp;
    logic [EXP_W-1:0]  obs_exp[2];

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Model: each group of up to BLKS value beats follows one exponent beat;
    // value beat j of a group pairs with exponent bytes j*GRPS .. j*GRPS+GRPS-1.
    task automatic build_job(input int n, input bit ramp);
        int left;
        logic [7:0] eb[DATA_W/8];
        logic [DATA_W-1:0] w;
        logic [EXP_W-1:0] e;
        left = n;
        while (left > 0) begin
            for (int k = 0; k < DATA_W / 8; k++) eb[k] = ramp ? 8'(120 + 4 * k) : 8'($urandom);
            for (int k = 0; k < DATA_W / 8; k++) w[k*8 +: 8] = eb[k];
            src_q.push_back(w);
            for (int j = 0; j < BLKS && left > 0; j++) begin
                w = rand_word();
                src_q.push_back(w);
                exp_val_q.push_back(w);
                e = '0;
                for (int q = 0; q < GRPS; q++) e[q*8 +: 8] = eb[j*GRPS + q];
                exp_exp_q.push_back(e);
                left--;
            end
        end
    endtask

    // Sample on the falling edge, drive 1 time unit after the rising edge.
    task automatic step();
        bit vld, xfer, infire;
        @(negedge clk);
        vld = val_valid;
        chk("valid_pair_equal", exp_valid, val_valid);
        if (prev_stall) begin
            chk("valid_held", vld, 1);
            chk("stall_val_stable", val_data, held_val);
            chk("stall_exp_stable", exp_data, held_exp);
        end
        xfer = vld && val_ready && exp_ready;
        if (xfer) begin
            if (exp_val_q.size() == 0) begin
                chk("unexpected_pair", 1, 0);
            end else begin
                chk("pair_val", val_data, exp_val_q.pop_front());
                chk("pair_exp", exp_data, exp_exp_q.pop_front());
                chk("done_on_last", done, exp_val_q.size() == 0);
            end
            if (pairs < 2) obs_exp[pairs] = exp_data;
            pairs++;
        end
        if (done) dones++;
        prev_stall = vld && !xfer;
        held_val = val_data;
        held_exp = exp_data;
        infire = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (infire) void'(src_q.pop_front());
        if (!(in_valid && !infire))
            in_valid = (src_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
        in_data = (src_q.size() > 0) ? src_q[0] : '0;
        case (rdy_mode)
            0: begin val_ready = 1'b1; exp_ready = 1'b1; end
            1: begin val_ready = ~val_ready; exp_ready = 1'b1; end
            default: begin val_ready = 1'($urandom_range(0, 1)); exp_ready = 1'($urandom_range(0, 1)); end
        endcase
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_in_ready"}, in_ready, 0);
        chk({pfx, "_val_valid"}, val_valid, 0);
        chk({pfx, "_exp_valid"}, exp_valid, 0);
        chk({pfx, "_val_data"}, val_data, 0);
        chk({pfx, "_exp_data"}, exp_data, 0);
    endtask

    task automatic run_job(input int n, input bit ramp, input int mode, input bit gp, input int spur);
        int cyc, ngrp;
        rdy_mode = mode;
        gaps = gp;
        build_job(n, ramp);
        ngrp = (n + BLKS - 1) / BLKS;
        pairs = 0;
        dones = 0;
        start = 1'b1;
        num = 16'(n);
        step();
        start = 1'b0;
        cyc = 0;
        while (dones == 0 && cyc < 400) begin
            if (cyc == spur) begin start = 1'b1; num = 16'd5; end
            step();
            start = 1'b0;
            cyc++;
        end
        chk("job_done_seen", dones, 1);
        chk("job_pair_count", pairs, n);
        chk("job_model_drained", exp_val_q.size(), 0);
        if (mode == 0 && !gp) chk("job_throughput", cyc <= n + ngrp + 1, 1);
        chk("job_end_busy", busy, 0);
        // A beat offered after the job must not be taken.
        src_q.delete();
        src_q.push_back(rand_word());
        in_valid = 1'b1;
        in_data = src_q[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_job_in_ready", in_ready, 0);
        end
        src_q.delete();
        exp_val_q.delete();
        exp_exp_q.delete();
        in_valid = 1'b0;
        in_data = '0;
        prev_stall = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_job(8, 1, 0, 0, -1);
        chk("ramp_pair0_exp", obs_exp[0], 64'h84807C78);
        chk("ramp_pair1_exp", obs_exp[1], 64'h94908C88);

        run_job(11, 1, 0, 0, -1);

        start = 1'b1;
        num = 16'd0;
        in_valid = 1'b1;
        in_data = rand_word();
        @(negedge clk);
        chk("n0_done_early", done, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("n0_done", done, 1);
        chk("n0_in_ready", in_ready, 0);
        chk("n0_val_valid", val_valid, 0);
        @(posedge clk);
        #1;
        chk("n0_done_once", done, 0);
        chk("n0_in_ready_late", in_ready, 0);
        in_valid = 1'b0;

        run_job(4, 0, 1, 0, -1);

        rdy_mode = 0;
        gaps = 0;
        build_job(8, 0);
        pairs = 0;
        start = 1'b1;
        num = 16'd8;
        step();
        start = 1'b0;
        for (int g = 0; g < 50 && pairs < 3; g++) step();
        rst = 1'b1;
        step();
        prev_stall = 0;
        chk_quiet("abort");
        rst = 1'b0;
        src_q.delete();
        exp_val_q.delete();
        exp_exp_q.delete();
        in_valid = 1'b0;
        dones = 0;
        for (int i = 0; i < 3; i++) step();
        chk("abort_no_done", dones, 0);
        run_job(2, 0, 0, 0, -1);

        run_job(8, 0, 0, 0, 3);

        for (int t = 0; t < 6; t++) run_job($urandom_range(1, 20), 0, 2, 1, -1);
        run_job(17, 0, 1, 1, 5);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
